// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: grant tags, CPU FSM states,
// bus widths and the default starvation limit.
package vram_arb_pkg;

  localparam int ADDR_W               = 10;
  localparam int DATA_W               = 8;
  localparam int STARVE_LIMIT_DEFAULT = 7;
  localparam logic [7:0] MISS_MAX     = 8'hFF;

  typedef enum logic [1:0] {NONE, VID, CPU_RD} grant_tag_e;

  typedef enum logic [1:0] {IDLE, WAIT, BUSY} cpu_state_e;

endpackage

// File: rtl/vram_arb_ret_pipe.sv
// Read-return pipeline: carries the grant tag alongside the RAM's one-cycle
// read latency and steers the registered read data to the video or CPU side.
module vram_arb_ret_pipe
  import vram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  grant_tag_e        i_tag,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_vid_data,
  output logic              o_vid_valid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack
);

  grant_tag_e        r_tag_s1;
  grant_tag_e        r_tag_s2;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_ack;

  // Stage 2 lines up with ram_rdata for the address issued one cycle earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_s1    <= NONE;
      r_tag_s2    <= NONE;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_tag_s1    <= i_tag;
      r_tag_s2    <= r_tag_s1;
      r_vid_valid <= (r_tag_s2 == VID);
      r_cpu_ack   <= (r_tag_s2 == CPU_RD);
      if (r_tag_s2 == VID)
        r_vid_data <= i_rdata;
      if (r_tag_s2 == CPU_RD)
        r_cpu_rdata <= i_rdata;
    end
  end

  assign o_vid_data  = r_vid_data;
  assign o_vid_valid = r_vid_valid;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between video fetch and an 8080-style CPU.
// Optional macro VRAM_VBLANK_LOCK_EN restricts CPU access to vertical blank.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        vid_miss
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  cpu_state_e        r_state;
  cpu_state_e        w_state_next;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [7:0]        r_vid_miss;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_wr_ack;
  grant_tag_e        w_tag;
  logic              w_rd_ack;
  logic              w_ack_cycle;
  logic              w_cpu_pend;
  logic              w_cpu_elig;
  logic              w_override_en;
  logic              w_starved;
  logic              w_cpu_gnt;
  logic              w_vid_gnt;
  logic              w_vid_drop;

`ifdef VRAM_VBLANK_LOCK_EN
  assign w_cpu_elig    = vblank;
  assign w_override_en = 1'b0;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_cpu_elig      = 1'b1;
  assign w_override_en   = 1'b1;
`endif

  // Requests are ignored while BUSY (including the ack cycle itself).
  assign w_cpu_pend  = cpu_req && (r_state != BUSY);
  assign w_starved   = w_override_en && (r_starve_cnt == STARVE_MAX);
  assign w_cpu_gnt   = w_cpu_pend && w_cpu_elig && (!vid_req || w_starved);
  assign w_vid_gnt   = vid_req && !w_cpu_gnt;
  assign w_vid_drop  = vid_req && w_cpu_gnt;
  assign w_ack_cycle = w_rd_ack || r_wr_ack;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cpu_req) w_state_next = w_cpu_gnt ? BUSY : WAIT;
      WAIT:    if (!cpu_req) w_state_next = IDLE;
               else if (w_cpu_gnt) w_state_next = BUSY;
      BUSY:    if (w_ack_cycle) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tag = NONE;
    if (w_vid_gnt)
      w_tag = VID;
    else if (w_cpu_gnt && !cpu_we)
      w_tag = CPU_RD;
  end

  // The write ack trails ram_we by one cycle, giving the grant+2 ack timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_vid_miss   <= '0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= '0;
      r_wr_ack     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ram_we <= w_cpu_gnt && cpu_we;
      r_wr_ack <= r_ram_we;
      if (w_cpu_gnt || !w_cpu_pend)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_MAX)
        r_starve_cnt <= r_starve_cnt + 1'b1;
      if (w_vid_drop && (r_vid_miss != MISS_MAX))
        r_vid_miss <= r_vid_miss + 8'd1;
      if (w_vid_gnt) begin
        r_ram_addr <= vid_addr;
      end else if (w_cpu_gnt) begin
        r_ram_addr <= cpu_addr;
        if (cpu_we)
          r_ram_wdata <= cpu_wdata;
      end
    end
  end

  vram_arb_ret_pipe u_ret_pipe (
    .clk         (clk),
    .reset       (reset),
    .i_tag       (w_tag),
    .i_rdata     (ram_rdata),
    .o_vid_data  (vid_data),
    .o_vid_valid (vid_valid),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ack   (w_rd_ack)
  );

  assign cpu_ack   = w_ack_cycle;
  assign cpu_ready = !(cpu_req && !w_ack_cycle);
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign vid_miss  = r_vid_miss;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios, then randomized traffic checked
// against a transaction-level model (default build; lock mode gets a directed test).
module tb_vram_arbiter;

  localparam int STARVE = 7;
  localparam int NRAND  = 600;

  logic       clk = 1'b0;
  logic       reset;
  logic       vblank;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic [7:0] vid_data;
  logic       vid_valid;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  logic       cpu_ready;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] vid_miss;

  logic [7:0] mem [0:1023];
  logic [7:0] shadow [0:1023];

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk       (clk),
    .reset     (reset),
    .vblank    (vblank),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_ready (cpu_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .vid_miss  (vid_miss)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we)
      mem[ram_addr] = ram_wdata;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vr, input logic [9:0] va, input logic cr,
                               input logic cw, input logic [9:0] ca, input logic [7:0] cd);
    vid_req   = vr;
    vid_addr  = va;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    bit         expValid [0:NRAND+7];
    logic [7:0] expVData [0:NRAND+7];
    bit         expAck   [0:NRAND+7];
    bit         expRdV   [0:NRAND+7];
    logic [7:0] expRData [0:NRAND+7];
    bit         expWe    [0:NRAND+7];
    logic [7:0] expWData [0:NRAND+7];
    bit         expAddrV [0:NRAND+7];
    logic [9:0] expAddr  [0:NRAND+7];
    logic [9:0] curAddr;
    logic [9:0] cAddr;
    logic [7:0] cData;
    logic [9:0] va;
    logic [7:0] vdCollide;
    bit         cWe, vr, quiet, cpuActive, cpuGranted, cpuWins, expReady;
    int         losses, missModel, ackCycle, gap, expMiss;

    reset  = 1'b1;
    vblank = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h155] = 8'hA5;
    mem[10'h020] = 8'h3C;
    vdCollide    = mem[10'h100];
    applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (3) nextCycle();

    checkOutput("rst_vid_valid", vid_valid, 0);
    checkOutput("rst_cpu_ack", cpu_ack, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_vid_miss", vid_miss, 0);
    checkOutput("rst_cpu_ready", cpu_ready, 1);
    reset = 1'b0;
    nextCycle();

    // Video-only read
    nextCycle(); applyStimulus(1'b1, 10'h155, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
    checkOutput("vid_ram_addr", ram_addr, 10'h155);
    checkOutput("vid_ram_we", ram_we, 0);
    nextCycle(); checkOutput("vid_valid_c2", vid_valid, 0);
    nextCycle(); checkOutput("vid_valid_c3", vid_valid, 1);
    checkOutput("vid_data_c3", vid_data, 8'hA5);
    nextCycle(); checkOutput("vid_valid_c4", vid_valid, 0);
    checkOutput("vid_miss_zero", vid_miss, 0);

    // CPU write then read-back
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 8'h7E);
    checkOutput("wr_ready_c0", cpu_ready, 0);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 8'h7E);
    checkOutput("wr_ram_we", ram_we, 1);
    checkOutput("wr_ram_addr", ram_addr, 10'h3FF);
    checkOutput("wr_ram_wdata", ram_wdata, 8'h7E);
    checkOutput("wr_ack_c1", cpu_ack, 0);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 8'h7E);
    checkOutput("wr_ack_c2", cpu_ack, 1);
    checkOutput("wr_ready_c2", cpu_ready, 1);
    checkOutput("wr_ram_we_c2", ram_we, 0);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
    checkOutput("wr_ack_c3", cpu_ack, 0);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 8'h00);
    nextCycle(); nextCycle(); nextCycle();
    checkOutput("rb_ack", cpu_ack, 1);
    checkOutput("rb_rdata", cpu_rdata, 8'h7E);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);

    // Collision: video wins cycle 0, CPU read granted cycle 1
    nextCycle(); applyStimulus(1'b1, 10'h100, 1'b1, 1'b0, 10'h020, 8'h00);
    checkOutput("col_ready_c0", cpu_ready, 0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 8'h00);
      if (c == 1) checkOutput("col_addr_c1", ram_addr, 10'h100);
      if (c == 2) checkOutput("col_addr_c2", ram_addr, 10'h020);
      if (c == 3) begin
        checkOutput("col_vid_valid", vid_valid, 1);
        checkOutput("col_vid_data", vid_data, vdCollide);
      end
      checkOutput("col_ack", cpu_ack, (c == 4) ? 1 : 0);
      checkOutput("col_ready", cpu_ready, (c == 4) ? 1 : 0);
    end
    checkOutput("col_rdata", cpu_rdata, 8'h3C);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
    nextCycle();

`ifndef VRAM_VBLANK_LOCK_EN
    // Starvation: video requests every cycle, CPU forced in after STARVE losses
    for (int r = 0; r < 300; r++) begin
      for (int c = 0; c <= 10; c++) begin
        nextCycle(); applyStimulus(1'b1, 10'(c * 37 + r), 1'b1, 1'b0, 10'h0AA, 8'h00);
        if (r == 0 && c == 7) checkOutput("starve_pre_vid", ram_addr, 10'(6 * 37));
        if (r == 0 && c == 8) begin
          checkOutput("starve_grant", ram_addr, 10'h0AA);
          checkOutput("starve_miss1", vid_miss, 1);
        end
        if (c == 10) begin
          expMiss = (r + 1 > 255) ? 255 : r + 1;
          checkOutput("starve_ack", cpu_ack, 1);
          checkOutput("starve_rdata", cpu_rdata, mem[10'h0AA]);
          checkOutput("starve_miss", vid_miss, expMiss);
        end
      end
    end
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
    repeat (3) nextCycle();
`endif

    // Reset during an in-flight CPU read
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h155, 8'h00);
    nextCycle(); reset = 1'b1; applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h155, 8'h00);
    checkOutput("rmid_addr_c1", ram_addr, 10'h155);
    nextCycle(); reset = 1'b0; applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
    checkOutput("rmid_ram_addr", ram_addr, 0);
    checkOutput("rmid_ram_wdata", ram_wdata, 0);
    checkOutput("rmid_ram_we", ram_we, 0);
    checkOutput("rmid_vid_data", vid_data, 0);
    checkOutput("rmid_cpu_rdata", cpu_rdata, 0);
    checkOutput("rmid_vid_miss", vid_miss, 0);
    checkOutput("rmid_cpu_ready", cpu_ready, 1);
    for (int c = 2; c <= 5; c++) begin
      checkOutput("rmid_no_ack", cpu_ack, 0);
      checkOutput("rmid_no_valid", vid_valid, 0);
      nextCycle();
    end

`ifdef VRAM_VBLANK_LOCK_EN
    // Lock mode: CPU write held off until vblank
    for (int c = 0; c < 20; c++) begin
      vblank = 1'b0;
      nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h011, 8'h5A);
      checkOutput("lock_no_we", ram_we, 0);
      checkOutput("lock_ready", cpu_ready, 0);
    end
    vblank = 1'b1;
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h011, 8'h5A);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h011, 8'h5A);
    checkOutput("lock_we", ram_we, 1);
    checkOutput("lock_addr", ram_addr, 10'h011);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h011, 8'h5A);
    checkOutput("lock_ack", cpu_ack, 1);
    nextCycle(); applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00);
`else
    // Randomized traffic against a transaction-level model
    for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
    for (int i = 0; i < NRAND + 8; i++) begin
      expValid[i] = 0; expAck[i] = 0; expRdV[i] = 0; expWe[i] = 0; expAddrV[i] = 0;
      expVData[i] = '0; expRData[i] = '0; expWData[i] = '0; expAddr[i] = '0;
    end
    curAddr = '0; losses = 0; missModel = 0; ackCycle = -1; gap = 0;
    cpuActive = 0; cpuGranted = 0; cWe = 0; cAddr = '0; cData = '0;
    for (int t = 0; t < NRAND; t++) begin
      nextCycle();
      quiet = (t >= NRAND - 10);
      if (!cpuActive) begin
        if (gap > 0) gap--;
        else if (!quiet && $urandom_range(0, 1) == 1) begin
          cpuActive = 1; cpuGranted = 0;
          cWe   = 1'($urandom_range(0, 1));
          cAddr = 10'($urandom_range(0, 1023));
          cData = 8'($urandom);
        end
      end
      vr      = !quiet && ($urandom_range(0, 3) != 0);
      va      = 10'($urandom_range(0, 1023));
      vblank  = 1'($urandom_range(0, 1));
      cpuWins = 0;
      if (cpuActive && !cpuGranted) begin
        if (!vr || losses == STARVE) begin
          cpuWins = 1; cpuGranted = 1; losses = 0;
          if (vr) missModel = (missModel == 255) ? 255 : missModel + 1;
          expAddrV[t+1] = 1; expAddr[t+1] = cAddr;
          if (cWe) begin
            shadow[cAddr] = cData;
            expWe[t+1] = 1; expWData[t+1] = cData;
            ackCycle = t + 2;
          end else begin
            ackCycle = t + 3;
            expRdV[t+3] = 1; expRData[t+3] = shadow[cAddr];
          end
          expAck[ackCycle] = 1;
        end else begin
          losses++;
        end
      end else begin
        losses = 0;
      end
      if (vr && !cpuWins) begin
        expAddrV[t+1] = 1; expAddr[t+1] = va;
        expValid[t+3] = 1; expVData[t+3] = shadow[va];
      end
      applyStimulus(vr, va, cpuActive, cWe, cAddr, cData);
      if (expAddrV[t]) curAddr = expAddr[t];
      expReady = !(cpuActive && !(cpuGranted && t == ackCycle));
      checkOutput("rnd_ram_addr", ram_addr, curAddr);
      checkOutput("rnd_ram_we", ram_we, expWe[t]);
      if (expWe[t]) checkOutput("rnd_ram_wdata", ram_wdata, expWData[t]);
      checkOutput("rnd_vid_valid", vid_valid, expValid[t]);
      if (expValid[t]) checkOutput("rnd_vid_data", vid_data, expVData[t]);
      checkOutput("rnd_cpu_ack", cpu_ack, expAck[t]);
      if (expRdV[t]) checkOutput("rnd_cpu_rdata", cpu_rdata, expRData[t]);
      checkOutput("rnd_cpu_ready", cpu_ready, expReady);
      if (cpuActive && cpuGranted && t == ackCycle) begin
        cpuActive = 0;
        gap = $urandom_range(0, 3);
      end
    end
    checkOutput("rnd_vid_miss", vid_miss, missModel);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
